// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter
//   Shares one single-port text buffer RAM between three users. The RAM is COLS x ROWS
//   characters and returns read data one cycle after it is enabled. The users are:
//     - video character fetch (highest priority, never stalled)
//     - clear-screen engine (fills every cell with one character)
//     - host port (lowest priority)
//   The arbiter grants at most one RAM access per clock.
//
//   Ports
//     clk, rst                   clock; asynchronous active-high reset
//     vid_req/vid_addr           video fetch request, one access per asserted cycle
//     vid_valid/vid_data         video read return, exactly one cycle after vid_req
//     host_req/host_we/host_addr/host_wdata
//                                host request, held stable until host_ack
//     host_ack/host_rdata        host completion pulse; read data is held until the next read ack
//     clr_start/clr_char         start a clear-screen pass with fill character clr_char
//     clr_busy/clr_done          clear in progress / one-cycle completion pulse
//     ram_en/ram_we/ram_addr/ram_wdata/ram_rdata
//                                single-port RAM interface; ram_* outputs are combinational from the grant
//
//   Handshakes
//     video: vid_req in cycle N always wins the RAM. vid_valid pulses in cycle N+1 with the data.
//     host : host_req is a request level that must stay stable until host_ack. The request is
//            granted in the first cycle with no video request and no clear in progress.
//            host_ack pulses in the following cycle. The host is never granted in its own
//            ack cycle, so a level held through the ack is not counted twice.
//     clear: clr_start is sampled only while the engine is idle. clr_busy covers the whole
//            pass, and clr_done pulses once when the pass ends.
//   Addresses at or beyond COLS*ROWS never enable the RAM. Reads to such addresses still
//   complete on schedule and return 0, and writes to them are dropped.
module text_buffer_arbiter #(
  parameter int CHARACTER_SET_COUNT = 20,
  parameter int COLS                = 80,
  parameter int ROWS                = 60,
  parameter int CHAR_W              = $clog2(CHARACTER_SET_COUNT),
  parameter int ADDR_W              = $clog2(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [CHAR_W-1:0] vid_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [CHAR_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [CHAR_W-1:0] host_rdata,
  input  logic              clr_start,
  input  logic [CHAR_W-1:0] clr_char,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [CHAR_W-1:0] ram_wdata,
  input  logic [CHAR_W-1:0] ram_rdata
);

  localparam int DEPTH = COLS * ROWS;
  // One extra bit keeps the range compare correct even when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  clr_state_e        clr_state_q,  clr_state_d;
  logic [ADDR_W-1:0] clr_cnt_q,    clr_cnt_d;
  logic [CHAR_W-1:0] clr_char_q,   clr_char_d;
  logic              vid_valid_q,  vid_valid_d;
  logic              vid_oor_q,    vid_oor_d;
  logic              host_ack_q,   host_ack_d;
  logic              host_rd_q,    host_rd_d;
  logic              host_oor_q,   host_oor_d;
  logic [CHAR_W-1:0] host_rdata_q, host_rdata_d;

  logic vid_in_range, host_in_range;
  logic gnt_vid, gnt_clr, gnt_host;

  assign clr_busy  = (clr_state_q == CLR_RUN);
  assign clr_done  = (clr_state_q == CLR_DONE);
  assign vid_valid = vid_valid_q;
  assign host_ack  = host_ack_q;

  // Grant and RAM drive
  always_comb begin
    vid_in_range  = ({1'b0, vid_addr}  < DEPTH_X);
    host_in_range = ({1'b0, host_addr} < DEPTH_X);
    gnt_vid  = vid_req;
    gnt_clr  = !vid_req && clr_busy;
    gnt_host = !vid_req && !clr_busy && host_req && !host_ack_q;

    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_vid) begin
      ram_en   = vid_in_range;
      ram_addr = vid_addr;
    end else if (gnt_clr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_q;
      ram_wdata = clr_char_q;
    end else if (gnt_host) begin
      ram_en    = host_in_range;
      ram_we    = host_in_range && host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  // Read returns
  // The RAM output is only meaningful in the cycle after an in-range read. Out-of-range
  // returns are forced to 0. Host read data is captured on its ack so that it stays
  // valid until the next read ack.
  always_comb begin
    vid_data = '0;
    if (vid_valid_q && !vid_oor_q) begin
      vid_data = ram_rdata;
    end

    host_rdata = host_rdata_q;
    if (host_ack_q && host_rd_q) begin
      host_rdata = host_oor_q ? '0 : ram_rdata;
    end
    host_rdata_d = host_rdata;

    vid_valid_d = gnt_vid;
    vid_oor_d   = !vid_in_range;
    host_ack_d  = gnt_host;
    host_rd_d   = gnt_host && !host_we;
    host_oor_d  = !host_in_range;
  end

  // Clear-screen engine
  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_char_d  = clr_char_q;
    case (clr_state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_d = CLR_RUN;
          clr_cnt_d   = '0;
          clr_char_d  = clr_char;
        end
      end
      CLR_RUN: begin
        // The counter only moves on cycles where the clear actually owns the RAM.
        // Video cycles therefore never skip or repeat an address.
        if (gnt_clr) begin
          if (clr_cnt_q == LAST_ADDR) begin
            clr_state_d = CLR_DONE;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      CLR_DONE: begin
        clr_state_d = CLR_IDLE;
      end
      default: begin
        clr_state_d = CLR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_state_q  <= CLR_IDLE;
      clr_cnt_q    <= '0;
      clr_char_q   <= '0;
      vid_valid_q  <= 1'b0;
      vid_oor_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rd_q    <= 1'b0;
      host_oor_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      clr_state_q  <= clr_state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_char_q   <= clr_char_d;
      vid_valid_q  <= vid_valid_d;
      vid_oor_q    <= vid_oor_d;
      host_ack_q   <= host_ack_d;
      host_rd_q    <= host_rd_d;
      host_oor_q   <= host_oor_d;
      host_rdata_q <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Bench for text_buffer_arbiter.
// The bench has these parts:
//   - a behavioural RAM that responds to ram_*;
//   - a memory-level reference model, with one array for contents and a few flags for
//     outstanding returns and clear progress;
//   - a table of directed vectors;
//   - hand-written multi-cycle sequences covering video starvation, clears, out-of-range
//     accesses and reset;
//   - a randomized video/host phase.
module tb_text_buffer_arbiter;
  localparam int DEPTH  = 4800;
  localparam int ADDR_W = 13;
  localparam int CHAR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [CHAR_W-1:0] vid_data;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [CHAR_W-1:0] host_wdata;
  logic              host_ack;
  logic [CHAR_W-1:0] host_rdata;
  logic              clr_start;
  logic [CHAR_W-1:0] clr_char;
  logic              clr_busy;
  logic              clr_done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [CHAR_W-1:0] ram_wdata;
  logic [CHAR_W-1:0] ram_rdata = '0;

  // clock
  always #5 clk = ~clk;

  text_buffer_arbiter #(
    .CHARACTER_SET_COUNT(20),
    .COLS(80),
    .ROWS(60)
  ) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_char(clr_char), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // single-port RAM, one-cycle read latency
  logic [CHAR_W-1:0] ram_mem [0:8191] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // reference model
  logic [CHAR_W-1:0] ref_mem [0:8191] = '{default: '0};
  logic              m_vpend = 1'b0;
  logic [CHAR_W-1:0] m_vexp  = '0;
  logic              m_ack   = 1'b0;
  logic [CHAR_W-1:0] m_rdata = '0;
  logic              m_busy  = 1'b0;
  logic              m_done  = 1'b0;
  int                m_pos   = 0;
  logic [CHAR_W-1:0] m_ch    = '0;
  int                obs_wr  = 0;
  int                n_total = 0;
  int                n_bad   = 0;

  typedef struct {
    logic              vr;
    logic [ADDR_W-1:0] va;
    logic              hr;
    logic              hw;
    logic [ADDR_W-1:0] ha;
    logic [CHAR_W-1:0] hd;
    logic              e_en;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic              e_valid;
    logic [CHAR_W-1:0] e_vd;
    logic              e_ack;
    logic [CHAR_W-1:0] e_hd;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: expected event did not occur at %0t", name, $time);
  endtask

  // Called once per cycle at the falling edge, with this cycle's inputs stable.
  // It first checks the outputs owed from the previous cycle and this cycle's RAM drive,
  // then advances the model by one clock.
  task automatic model_step();
    logic              g_vid, g_clr, g_host, e_en, e_we, n_busy, n_done;
    logic [ADDR_W-1:0] e_addr;
    logic [CHAR_W-1:0] e_wd;
    chk("vid_valid", vid_valid, m_vpend);
    if (m_vpend) chk("vid_data", vid_data, m_vexp);
    chk("host_ack", host_ack, m_ack);
    chk("host_rdata", host_rdata, m_rdata);
    chk("clr_busy", clr_busy, m_busy);
    chk("clr_done", clr_done, m_done);

    g_vid  = vid_req;
    g_clr  = !vid_req && m_busy;
    g_host = !vid_req && !m_busy && host_req && !m_ack;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (g_vid) begin
      e_en = (vid_addr < DEPTH); e_addr = vid_addr;
    end else if (g_clr) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = ADDR_W'(m_pos); e_wd = m_ch;
    end else if (g_host) begin
      e_en = (host_addr < DEPTH); e_we = host_we; e_addr = host_addr; e_wd = host_wdata;
    end
    chk("ram_en", ram_en, e_en);
    if (e_en) begin
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      if (e_we) chk("ram_wdata", ram_wdata, e_wd);
    end
    if (ram_en && ram_we) obs_wr++;

    m_vpend = g_vid;
    m_vexp  = (vid_addr < DEPTH) ? ref_mem[vid_addr] : '0;
    m_ack   = g_host;
    if (g_host && host_addr < DEPTH) begin
      if (host_we) ref_mem[host_addr] = host_wdata;
      else         m_rdata = ref_mem[host_addr];
    end else if (g_host && !host_we) begin
      m_rdata = '0;
    end
    n_busy = m_busy;
    n_done = 1'b0;
    if (g_clr) begin
      ref_mem[m_pos] = m_ch;
      if (m_pos == DEPTH - 1) begin
        n_busy = 1'b0;
        n_done = 1'b1;
      end
      m_pos++;
    end else if (!m_busy && !m_done && clr_start) begin
      n_busy = 1'b1;
      m_pos  = 0;
      m_ch   = clr_char;
    end
    m_busy = n_busy;
    m_done = n_done;
  endtask

  task automatic model_reset();
    m_vpend = 1'b0; m_ack = 1'b0; m_rdata = '0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_clr_busy"}, clr_busy, 0);
    chk({tag, "_clr_done"}, clr_done, 0);
    chk({tag, "_host_ack"}, host_ack, 0);
    chk({tag, "_vid_valid"}, vid_valid, 0);
    chk({tag, "_vid_data"}, vid_data, 0);
    chk({tag, "_host_rdata"}, host_rdata, 0);
  endtask

  task automatic host_access(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [CHAR_W-1:0] d, output logic [CHAR_W-1:0] rd);
    logic got;
    got = 1'b0; rd = '0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = host_ack;
      rd  = host_rdata;
      model_step();
      @(posedge clk);
      #1;
    end
    host_req = 1'b0; host_we = 1'b0;
    if (!got) fail_now("host_ack_timeout");
  endtask

  // Runs cycles until clr_done is seen, optionally with 50% random video traffic.
  // Returns the cycle index, counted from 1 after the start cycle, or -1 on timeout.
  task automatic run_clear(input bit with_video, input int limit, output int done_cyc);
    logic seen;
    done_cyc = -1;
    for (int c = 1; c < limit; c++) begin
      if (with_video) begin
        vid_req  = 1'($urandom_range(0, 1));
        vid_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      end
      @(negedge clk);
      seen = clr_done;
      model_step();
      @(posedge clk);
      #1;
      clr_start = 1'b0;
      if (seen) begin
        done_cyc = c;
        break;
      end
    end
    vid_req = 1'b0;
    if (done_cyc < 0) fail_now("clr_done_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CHAR_W-1:0] rd;
    logic              ack_seen;
    int                base, done_cyc;

    // reset
    rst = 1'b1; vid_req = 1'b0; vid_addr = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; clr_start = 1'b0; clr_char = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_ram_en", ram_en, 0);
    rst = 1'b0;

    // directed vectors: {vr, va, hr, hw, ha, hd | en, we, addr | valid, vdata, ack, hdata}
    tbl[0]  = '{1'b0, 13'd0,    1'b1, 1'b1, 13'd5,    5'h0A, 1'b1, 1'b1, 13'd5,    1'b0, 5'h00, 1'b1, 5'h00};
    tbl[1]  = '{1'b0, 13'd0,    1'b1, 1'b0, 13'd5,    5'h00, 1'b1, 1'b0, 13'd5,    1'b0, 5'h00, 1'b1, 5'h0A};
    tbl[2]  = '{1'b0, 13'd0,    1'b1, 1'b1, 13'd10,   5'h03, 1'b1, 1'b1, 13'd10,   1'b0, 5'h00, 1'b1, 5'h0A};
    tbl[3]  = '{1'b1, 13'd5,    1'b1, 1'b0, 13'd10,   5'h00, 1'b1, 1'b0, 13'd5,    1'b1, 5'h0A, 1'b0, 5'h0A};
    tbl[4]  = '{1'b1, 13'd4800, 1'b0, 1'b0, 13'd0,    5'h00, 1'b0, 1'b0, 13'd0,    1'b1, 5'h00, 1'b0, 5'h0A};
    tbl[5]  = '{1'b0, 13'd0,    1'b1, 1'b0, 13'd4800, 5'h00, 1'b0, 1'b0, 13'd0,    1'b0, 5'h00, 1'b1, 5'h00};
    tbl[6]  = '{1'b0, 13'd0,    1'b1, 1'b1, 13'd4800, 5'h07, 1'b0, 1'b0, 13'd0,    1'b0, 5'h00, 1'b1, 5'h00};
    tbl[7]  = '{1'b0, 13'd0,    1'b1, 1'b1, 13'd4799, 5'h13, 1'b1, 1'b1, 13'd4799, 1'b0, 5'h00, 1'b1, 5'h00};
    tbl[8]  = '{1'b1, 13'd4799, 1'b0, 1'b0, 13'd0,    5'h00, 1'b1, 1'b0, 13'd4799, 1'b1, 5'h13, 1'b0, 5'h00};
    tbl[9]  = '{1'b0, 13'd0,    1'b1, 1'b0, 13'd4799, 5'h00, 1'b1, 1'b0, 13'd4799, 1'b0, 5'h00, 1'b1, 5'h13};
    tbl[10] = '{1'b1, 13'd10,   1'b0, 1'b0, 13'd0,    5'h00, 1'b1, 1'b0, 13'd10,   1'b1, 5'h03, 1'b0, 5'h13};
    tbl[11] = '{1'b0, 13'd0,    1'b0, 1'b0, 13'd0,    5'h00, 1'b0, 1'b0, 13'd0,    1'b0, 5'h00, 1'b0, 5'h13};
    for (int i = 0; i < 12; i++) begin
      vid_req = tbl[i].vr; vid_addr = tbl[i].va;
      host_req = tbl[i].hr; host_we = tbl[i].hw; host_addr = tbl[i].ha; host_wdata = tbl[i].hd;
      @(negedge clk);
      chk($sformatf("tbl%0d_ram_en", i), ram_en, tbl[i].e_en);
      if (tbl[i].e_en) begin
        chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].e_we);
        chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].e_addr);
      end
      model_step();
      @(posedge clk);
      #1;
      vid_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_vid_valid", i), vid_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_vid_data", i), vid_data, tbl[i].e_vd);
      chk($sformatf("tbl%0d_host_ack", i), host_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_host_rdata", i), host_rdata, tbl[i].e_hd);
      model_step();
      @(posedge clk);
      #1;
    end

    // video held for 10 cycles starves a pending host read; the ack comes one cycle after the drop
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd5;
    for (int k = 0; k < 10; k++) begin
      vid_req  = 1'b1;
      vid_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      tick();
    end
    vid_req = 1'b0;
    tick();
    @(negedge clk);
    chk("starve_host_ack", host_ack, 1);
    chk("starve_host_rdata", host_rdata, 5'h0A);
    model_step();
    @(posedge clk);
    #1;
    host_req = 1'b0;
    tick();

    // randomized video and host traffic
    for (int c = 0; c < 400; c++) begin
      vid_req  = 1'($urandom_range(0, 1));
      vid_addr = ($urandom_range(0, 7) == 0) ? ADDR_W'(DEPTH + $urandom_range(0, 100))
                                             : ADDR_W'($urandom_range(0, 63));
      if (!host_req && $urandom_range(0, 1) == 1) begin
        host_req   = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'(DEPTH + $urandom_range(0, 100))
                                                 : ADDR_W'($urandom_range(0, 63));
        host_wdata = CHAR_W'($urandom_range(0, 19));
      end
      @(negedge clk);
      ack_seen = host_ack;
      model_step();
      @(posedge clk);
      #1;
      if (ack_seen) host_req = 1'b0;
    end
    vid_req = 1'b0; host_req = 1'b0;
    tick();
    tick();

    // clear without video; a second start mid-clear is ignored
    base = obs_wr;
    clr_char = 5'h03; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (99) tick();
    clr_char = 5'h07; clr_start = 1'b1;
    tick();
    clr_start = 1'b0; clr_char = 5'h03;
    run_clear(1'b0, 6000, done_cyc);
    chk("clr_done_latency", done_cyc + 100, 4801);
    chk("clr_write_count", obs_wr - base, 4800);
    for (int i = 0; i < 8; i++) begin
      host_access(1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)), '0, rd);
      chk("clr_readback", rd, 5'h03);
    end

    // clear with 50% video traffic
    base = obs_wr;
    clr_char = 5'h11; clr_start = 1'b1;
    run_clear(1'b1, 12000, done_cyc);
    chk("clr2_write_count", obs_wr - base, 4800);
    host_access(1'b0, 13'd0, '0, rd);
    chk("clr2_first_cell", rd, 5'h11);
    host_access(1'b0, 13'd4799, '0, rd);
    chk("clr2_last_cell", rd, 5'h11);

    // reset mid-clear
    clr_char = 5'h0C; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 3000 && m_pos != 2000; k++) tick();
    if (m_pos != 2000) fail_now("mid_clear_reach");
    rst = 1'b1;
    #1;
    check_zero("rst_clear");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();

    // reset during a granted host access
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd7;
    @(negedge clk);
    chk("rst_host_granted", ram_en, 1);
    rst = 1'b1; host_req = 1'b0;
    #1;
    check_zero("rst_host");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();

    // host write and clr_start in the same idle cycle
    base = obs_wr;
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'd100; host_wdata = 5'h09;
    clr_start = 1'b1; clr_char = 5'h05;
    @(negedge clk);
    chk("sim_ram_en", ram_en, 1);
    chk("sim_ram_we", ram_we, 1);
    chk("sim_ram_addr", ram_addr, 100);
    chk("sim_ram_wdata", ram_wdata, 5'h09);
    model_step();
    @(posedge clk);
    #1;
    clr_start = 1'b0; host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("sim_host_ack", host_ack, 1);
    chk("sim_clr_busy", clr_busy, 1);
    model_step();
    @(posedge clk);
    #1;
    run_clear(1'b0, 6000, done_cyc);
    chk("sim_write_count", obs_wr - base, 4801);
    host_access(1'b0, 13'd100, '0, rd);
    chk("sim_cell100", rd, 5'h05);
    host_access(1'b0, 13'd1999, '0, rd);
    chk("sim_cell1999", rd, 5'h05);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
